// File: rtl/frame_writer.sv
// Packs RGB333 pixels three per 32-bit word, queues {last, addr, data} entries in a FIFO
// and writes them one word at a time to ram_ctrl over the write/workdone handshake.
module frame_writer #(
    parameter logic [19:0] BASE_ADDR    = 20'h00000,
    parameter int          FRAME_PIXELS = 307200,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [8:0]  pix_data,
    input  logic        frame_start,
    output logic        write,
    output logic [19:0] inp_addr,
    output logic [31:0] inp_data,
    input  logic        workdone,
    output logic        frame_done,
    output logic        overflow,
    output logic [3:0]  sta
);
    localparam int CW   = $clog2(FRAME_PIXELS + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int EW   = 53;
    localparam logic [CW-1:0]   FP_CNT   = CW'(FRAME_PIXELS);
    localparam logic [CW-1:0]   LAST_PIX = CW'(FRAME_PIXELS - 1);
    localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;

    logic [1:0]    slot_q, slot_d, slot_eff;
    logic [17:0]   part_q, part_d, part_eff;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic [19:0]   waddr_q, waddr_d, waddr_eff;
    logic          accept, push, push_last;
    logic [26:0]   word;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CNTW-1:0] fcnt_q;
    logic            overflow_q;
    logic            pop, push_ok, fifo_empty;
    logic [EW-1:0]   head;

    logic [1:0]  state_q;
    logic        write_q, last_q, frame_done_q;
    logic [19:0] addr_q;
    logic [31:0] data_q;

    // frame_start takes effect combinationally so a pixel in the same cycle lands in slot 0.
    always_comb begin
        slot_eff  = frame_start ? 2'd0 : slot_q;
        part_eff  = frame_start ? 18'd0 : part_q;
        cnt_eff   = frame_start ? '0 : cnt_q;
        waddr_eff = frame_start ? BASE_ADDR : waddr_q;
        accept    = pix_valid && (cnt_eff != FP_CNT);
        push_last = accept && (cnt_eff == LAST_PIX);
        push      = accept && ((slot_eff == 2'd2) || push_last);
        case (slot_eff)
            2'd0:    word = {18'd0, pix_data};
            2'd1:    word = {9'd0, pix_data, part_eff[8:0]};
            default: word = {pix_data, part_eff};
        endcase
        slot_d  = slot_eff;
        part_d  = part_eff;
        cnt_d   = cnt_eff;
        waddr_d = waddr_eff;
        if (accept) begin
            cnt_d = cnt_eff + CW'(1);
            if (push) begin
                slot_d  = 2'd0;
                part_d  = 18'd0;
                waddr_d = waddr_eff + 20'd1;
            end else begin
                slot_d = slot_eff + 2'd1;
                part_d = word[17:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q  <= 2'd0;
            part_q  <= 18'd0;
            cnt_q   <= '0;
            waddr_q <= BASE_ADDR;
        end else begin
            slot_q  <= slot_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
        end
    end

    assign pop        = (state_q == ST_REQ) && workdone;
    assign fifo_empty = (fcnt_q == '0);
    assign push_ok    = push && ((fcnt_q != DEPTH) || pop);
    assign head       = mem_q[rptr_q];

    // Dropped words still advance the address counter, so the frame layout is preserved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (push && !push_ok) overflow_q <= 1'b1;
            case ({push_ok, pop})
                2'b10:   fcnt_q <= fcnt_q + CNTW'(1);
                2'b01:   fcnt_q <= fcnt_q - CNTW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= {push_last, waddr_eff, 5'd0, word};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addr_q       <= 20'd0;
            data_q       <= 32'd0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!fifo_empty && !workdone) begin
                    write_q <= 1'b1;
                    addr_q  <= head[51:32];
                    data_q  <= head[31:0];
                    last_q  <= head[52];
                    state_q <= ST_REQ;
                end
                ST_REQ: if (workdone) begin
                    write_q      <= 1'b0;
                    frame_done_q <= last_q;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: if (!workdone) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign write      = write_q;
    assign inp_addr   = addr_q;
    assign inp_data   = data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign sta        = {overflow_q, fifo_empty, state_q};
endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: a ram_ctrl responder records every request, and a
// frame-level pixel model predicts the words each frame must produce.
module tb_frame_writer;
    localparam logic [19:0] BASE  = 20'h00100;
    localparam int          FP    = 7;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, pix_valid, frame_start, workdone;
    logic [8:0]  pix_data;
    logic        write, frame_done, overflow;
    logic [19:0] inp_addr;
    logic [31:0] inp_data;
    logic [3:0]  sta;

    int checks = 0;
    int errors = 0;

    bit ram_en = 1'b1;
    bit stick = 1'b0;
    int ram_lat = 3;
    int lat = 0, unstable = 0, fd_cnt = 0, fd_bad = 0;
    logic [19:0] hold_a;
    logic [31:0] hold_d;
    logic [19:0] cap_addr[$];
    logic [31:0] cap_data[$];

    logic [8:0]  m_pix[$];
    logic [19:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];

    frame_writer #(.BASE_ADDR(BASE), .FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .frame_start(frame_start), .write(write), .inp_addr(inp_addr),
        .inp_data(inp_data), .workdone(workdone), .frame_done(frame_done),
        .overflow(overflow), .sta(sta)
    );

    always #5 clk = ~clk;

    // ram_ctrl responder: acks ram_lat cycles into a request, then drops workdone unless stuck.
    initial begin
        workdone = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (frame_done) begin
                fd_cnt++;
                if (!workdone) fd_bad++;
            end
            if (write && !workdone) begin
                if (lat == 0) begin
                    cap_addr.push_back(inp_addr);
                    cap_data.push_back(inp_data);
                    hold_a = inp_addr;
                    hold_d = inp_data;
                end else if (inp_addr !== hold_a || inp_data !== hold_d) begin
                    unstable++;
                end
                lat++;
                if (ram_en && lat >= ram_lat) workdone = 1'b1;
            end else if (!write) begin
                if (!stick) workdone = 1'b0;
                lat = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word k of a frame holds frame pixels 3k..3k+2 at 9-bit spacing, flushed early at pixel FP-1.
    task automatic model(input bit v, input logic [8:0] d, input bit fs);
        int n, k;
        logic [31:0] w;
        if (fs) m_pix.delete();
        if (v && m_pix.size() < FP) begin
            m_pix.push_back(d);
            n = m_pix.size();
            if (n % 3 == 0 || n == FP) begin
                k = (n - 1) / 3;
                w = 32'd0;
                for (int i = 3 * k; i < n; i++) w += 32'(m_pix[i]) << (9 * (i - 3 * k));
                exp_addr.push_back(BASE + 20'(k));
                exp_data.push_back(w);
                exp_last.push_back(n == FP);
            end
        end
    endtask

    task automatic drive(input bit v, input logic [8:0] d, input bit fs);
        pix_valid = v;
        pix_data = d;
        frame_start = fs;
        model(v, d, fs);
        tick();
        pix_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        pix_data = 9'd0;
        stick = 1'b0;
        ram_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        cap_addr.delete(); cap_data.delete();
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        m_pix.delete();
        unstable = 0; fd_cnt = 0; fd_bad = 0;
    endtask

    task automatic wait_idle(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cap_addr.size() >= n && sta[2] && sta[1:0] == 2'b00 && !write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; pix_data = 9'd0;
        tick();
        tick();
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", write); end
        checks++; if (inp_addr !== 20'd0) begin errors++; $display("FAIL reset_addr got %h want 0", inp_addr); end
        checks++; if (inp_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", inp_data); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone got %b want 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (sta !== 4'h4) begin errors++; $display("FAIL reset_sta got %h want 4", sta); end
    endtask

    task automatic test_single_word();
        bit ok;
        apply_reset();
        ram_lat = 3;
        drive(1'b1, 9'h1FF, 1'b1);
        drive(1'b1, 9'h000, 1'b0);
        drive(1'b1, 9'h0AA, 1'b0);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL single_early_write got %b want 0", write); end
        tick();
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", write); end
        checks++; if (inp_addr !== BASE) begin errors++; $display("FAIL single_addr got %h want %h", inp_addr, BASE); end
        checks++; if (inp_data !== 32'h02A801FF) begin errors++; $display("FAIL single_data got %h want 02a801ff", inp_data); end
        checks++; if (sta !== 4'h1) begin errors++; $display("FAIL single_sta_req got %h want 1", sta); end
        wait_idle(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy want idle"); end
        checks++; if (cap_addr.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", cap_addr.size()); end
        checks++; if (sta !== 4'h4) begin errors++; $display("FAIL single_sta_idle got %h want 4", sta); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL single_stable got %0d want 0", unstable); end
    endtask

    task automatic test_frame_end();
        bit ok;
        apply_reset();
        ram_lat = 1;
        for (int p = 1; p <= 8; p++) drive(1'b1, 9'(p), p == 1);
        wait_idle(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fend_timeout got busy want idle"); end
        checks++; if (cap_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL fend_count got %0d want %0d", cap_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            checks++; if (cap_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL fend_addr%0d got %h want %h", i, cap_addr[i], exp_addr[i]); end
            checks++; if (cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL fend_data%0d got %h want %h", i, cap_data[i], exp_data[i]); end
        end
        if (cap_data.size() >= 3) begin
            checks++; if (cap_data[2] !== 32'h00000007) begin errors++; $display("FAIL fend_partial got %h want 00000007", cap_data[2]); end
        end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL fend_fdone_count got %0d want 1", fd_cnt); end
        checks++; if (fd_bad !== 0) begin errors++; $display("FAIL fend_fdone_timing got %0d want 0", fd_bad); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fend_ovf got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        ram_en = 1'b0;
        ram_lat = 2;
        for (int p = 0; p < 7; p++) drive(1'b1, 9'($urandom), p == 0);
        for (int p = 0; p < 3; p++) drive(1'b1, 9'($urandom), p == 0);
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (sta[3] !== 1'b1) begin errors++; $display("FAIL ovf_sta got %b want 1", sta[3]); end
        checks++; if (write !== 1'b1 || inp_addr !== BASE) begin errors++; $display("FAIL ovf_held got %b/%h want 1/%h", write, inp_addr, BASE); end
        ram_en = 1'b1;
        wait_idle(2, ok);
        for (int p = 0; p < 3; p++) drive(1'b1, 9'($urandom), p == 0);
        wait_idle(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy want idle"); end
        checks++; if (cap_addr.size() !== 3 || exp_addr.size() !== 5) begin errors++; $display("FAIL ovf_count got %0d want 3", cap_addr.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                int j = (i < 2) ? i : 4;
                checks++; if (cap_addr[i] !== exp_addr[j] || cap_data[i] !== exp_data[j]) begin errors++; $display("FAIL ovf_word%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[j], exp_data[j]); end
            end
        end
        checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL ovf_fdone got %0d want 0", fd_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_restart();
        bit ok;
        apply_reset();
        ram_lat = 2;
        for (int p = 0; p < 4; p++) drive(1'b1, 9'($urandom), p == 0);
        for (int p = 0; p < 3; p++) drive(1'b1, 9'($urandom), p == 0);
        wait_idle(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got busy want idle"); end
        checks++; if (cap_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL restart_count got %0d want %0d", cap_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            checks++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL restart_word%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int extra = 0;
        apply_reset();
        ram_lat = 4;
        stick = 1'b1;
        for (int p = 0; p < 6; p++) drive(1'b1, 9'($urandom), p == 0);
        for (int i = 0; i < 40 && !(cap_addr.size() >= 1 && sta[1:0] == 2'b10); i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (write) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hs_no_write got %0d want 0", extra); end
        checks++; if (sta[1:0] !== 2'b10) begin errors++; $display("FAIL hs_wait_low got %b want 10", sta[1:0]); end
        stick = 1'b0;
        wait_idle(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hs_timeout got busy want idle"); end
        checks++; if (cap_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL hs_count got %0d want %0d", cap_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            checks++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL hs_word%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL hs_stable got %0d want 0", unstable); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ram_en = 1'b0;
        for (int p = 0; p < 3; p++) drive(1'b1, 9'($urandom), p == 0);
        for (int i = 0; i < 10 && !write; i++) tick();
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", write); end
        rst = 1'b0;
        tick();
        checks++; if (write !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got %b%b%b want 000", write, frame_done, overflow); end
        checks++; if (inp_addr !== 20'd0 || inp_data !== 32'd0) begin errors++; $display("FAIL rmid_bus got %h:%h want 0:0", inp_addr, inp_data); end
        checks++; if (sta !== 4'h4) begin errors++; $display("FAIL rmid_sta got %h want 4", sta); end
        rst = 1'b1;
        ram_en = 1'b1;
        repeat (10) tick();
        checks++; if (cap_addr.size() !== 1 || fd_cnt !== 0) begin errors++; $display("FAIL rmid_abandon got %0d/%0d want 1/0", cap_addr.size(), fd_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        int lasts = 0;
        apply_reset();
        ram_lat = $urandom_range(1, 3);
        for (int it = 0; it < 120; it++) begin
            drive($urandom_range(0, 4) != 0, 9'($urandom), $urandom_range(0, 7) == 0);
            repeat ($urandom_range(3, 5)) tick();
        end
        wait_idle(exp_addr.size(), ok);
        foreach (exp_last[i]) if (exp_last[i]) lasts++;
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got busy want idle"); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b want 0", overflow); end
        checks++; if (cap_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", cap_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            checks++; if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin errors++; $display("FAIL rand_word%0d got %h:%h want %h:%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]); end
        end
        checks++; if (fd_cnt !== lasts || fd_bad !== 0) begin errors++; $display("FAIL rand_fdone got %0d/%0d want %0d/0", fd_cnt, fd_bad, lasts); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL rand_stable got %0d want 0", unstable); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame_end();
        test_overflow();
        test_restart();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
